// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and geometry defaults for the data cache controller
package dcache_pkg;
    localparam int ADR_W_DEF   = 15;
    localparam int INDEX_W_DEF = 8;
    localparam int OFF_W       = 2;
    localparam int TAG_W_DEF   = ADR_W_DEF - INDEX_W_DEF - OFF_W;
    typedef enum logic [2:0] {IDLE, COMPARE, CLEAR, WAIT, FILL, RESP} state_t;
endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/tag/data arrays, combinational read, synchronous line fill
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INDEX_W-1:0]   idx,
    input  logic                 we,
    input  logic [TAG_W-1:0]     wtag,
    input  logic [3:0][31:0]     wdata,
    output logic                 rvalid,
    output logic [TAG_W-1:0]     rtag,
    output logic [3:0][31:0]     rdata
);
    localparam int LINES = 1 << INDEX_W;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [3:0][31:0] data [LINES];
    assign rvalid = valid[idx];
    assign rtag   = tags[idx];
    assign rdata  = data[idx];
    // valid bits are the only state that reset has to clear
    always_ff @(posedge clk)
        if (rst) valid <= '0;
        else if (we) valid[idx] <= 1'b1;
    // tag and data payload, written whole-line on fill
    always_ff @(posedge clk)
        if (we) begin
            tags[idx] <= wtag;
            data[idx] <= wdata;
        end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped read cache controller; DCACHE_STATS_EN adds hit/miss counters
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADR_W   = ADR_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_rd,
    input  logic [ADR_W-1:0] cpu_adr,
    output logic             cpu_busy,
    output logic             cpu_ready,
    output logic [31:0]      cpu_data,
    output logic             cpu_hit,
    output logic             mem_start,
    output logic             mem_forc,
    output logic [ADR_W-1:0] mem_adr,
    input  logic             mem_ready,
    input  logic [31:0]      mem_w0,
    input  logic [31:0]      mem_w1,
    input  logic [31:0]      mem_w2,
`ifdef DCACHE_STATS_EN
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt,
`endif
    input  logic [31:0]      mem_w3
);
    localparam int TAG_W = ADR_W - INDEX_W - OFF_W;
    state_t state, nxt;
    logic [ADR_W-1:0] adr_q;
    logic [31:0] data_q;
    logic line_valid, hit, we;
    logic [TAG_W-1:0] line_tag;
    logic [3:0][31:0] line_data;
    logic [31:0] word;
    assign hit  = line_valid && line_tag == adr_q[ADR_W-1:INDEX_W+OFF_W];
    assign word = line_data[adr_q[OFF_W-1:0]];
    assign we   = state == FILL && !rst;
    dcache_line_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_store (
        .clk   (clk),
        .rst   (rst),
        .idx   (adr_q[INDEX_W+OFF_W-1:OFF_W]),
        .we    (we),
        .wtag  (adr_q[ADR_W-1:INDEX_W+OFF_W]),
        .wdata ({mem_w3, mem_w2, mem_w1, mem_w0}),
        .rvalid(line_valid),
        .rtag  (line_tag),
        .rdata (line_data)
    );
    // state, latched request address and the held response word
    always_ff @(posedge clk)
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && cpu_rd) adr_q <= cpu_adr;
            if (cpu_ready) data_q <= word;
        end
    // next state and outputs; the response word bypasses data_q in its ready cycle
    always_comb begin
        nxt       = state;
        cpu_busy  = state != IDLE;
        cpu_hit   = state == COMPARE && hit;
        cpu_ready = cpu_hit || state == RESP;
        cpu_data  = cpu_ready ? word : data_q;
        mem_forc  = state == CLEAR;
        mem_start = state == WAIT;
        mem_adr   = {adr_q[ADR_W-1:OFF_W], {OFF_W{1'b0}}};
        case (state)
            IDLE:    nxt = cpu_rd ? COMPARE : IDLE;
            COMPARE: nxt = hit ? IDLE : CLEAR;
            CLEAR:   nxt = WAIT;
            WAIT:    nxt = mem_ready ? FILL : WAIT;
            FILL:    nxt = RESP;
            default: nxt = IDLE;
        endcase
    end
`ifdef DCACHE_STATS_EN
    // saturating hit/miss counters, one step per cpu_ready pulse
    always_ff @(posedge clk)
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (cpu_ready) begin
            if (cpu_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            if (!cpu_hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and random reads against a tag-map reference model
module tb_dcache_ctrl;
    logic clk = 0, rst = 1, cpu_rd = 0;
    logic [14:0] cpu_adr = '0;
    logic cpu_busy, cpu_ready, cpu_hit, mem_start, mem_forc;
    logic [31:0] cpu_data;
    logic [14:0] mem_adr;
    logic mem_ready = 0;
    logic [31:0] mem_w0, mem_w1, mem_w2, mem_w3;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif
    int n_cmp = 0, n_err = 0;
    bit mvalid [256];
    logic [4:0] mtag [256];
    int exp_hits = 0, exp_misses = 0;

    dcache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_adr(cpu_adr),
        .cpu_busy(cpu_busy), .cpu_ready(cpu_ready), .cpu_data(cpu_data), .cpu_hit(cpu_hit),
        .mem_start(mem_start), .mem_forc(mem_forc), .mem_adr(mem_adr), .mem_ready(mem_ready),
        .mem_w0(mem_w0), .mem_w1(mem_w1), .mem_w2(mem_w2),
`ifdef DCACHE_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .mem_w3(mem_w3)
    );

    always #5 clk = ~clk;

    // memory model: word i holds value i; ready rises a cycle after start, cleared by forc
    always @(posedge clk)
        if (mem_forc) mem_ready <= 1'b0;
        else if (mem_start) mem_ready <= 1'b1;
    assign mem_w0 = {17'b0, mem_adr};
    assign mem_w1 = {17'b0, mem_adr} + 32'd1;
    assign mem_w2 = {17'b0, mem_adr} + 32'd2;
    assign mem_w3 = {17'b0, mem_adr} + 32'd3;

    task automatic do_reset();
        @(negedge clk); rst = 1; cpu_rd = 0;
        @(negedge clk); rst = 0;
        for (int i = 0; i < 256; i++) mvalid[i] = 0;
        exp_hits = 0; exp_misses = 0;
    endtask

    // one read; checks outcome, latency, memory handshake and data hold against the model
    task automatic run_read(input logic [14:0] a, input bit hold, input string nm);
        bit exp_hit, got_hit, both, bad_order, bad_adr, done;
        int readies, forcs, starts, lat;
        logic [31:0] got_data, exp_data;
        exp_hit = mvalid[a[9:2]] && mtag[a[9:2]] == a[14:10];
        exp_data = {17'b0, a};
        readies = 0; forcs = 0; starts = 0; lat = 0; both = 0; bad_order = 0; bad_adr = 0; done = 0;
        got_hit = 0; got_data = '0;
        @(negedge clk); cpu_rd = 1; cpu_adr = a;
        @(posedge clk);
        #1;
        if (!hold) begin cpu_rd = 0; cpu_adr = 15'($urandom); end
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (mem_forc && mem_start) both = 1;
            if (mem_forc) forcs++;
            if (mem_start) begin
                if (forcs == 0) bad_order = 1;
                if (mem_adr !== (a & 15'h7FFC)) bad_adr = 1;
                starts++;
            end
            if (cpu_ready) begin
                readies++;
                if (readies == 1) begin lat = c; got_hit = cpu_hit; got_data = cpu_data; end
            end
            if (!cpu_busy) begin cpu_rd = 0; done = 1; end
        end
        cpu_rd = 0;
        n_cmp++; if (!done) begin n_err++; $display("FAIL %s timeout: busy still %b after 20 cycles", nm, cpu_busy); end
        n_cmp++; if (readies != 1) begin n_err++; $display("FAIL %s ready_count: got %0d want 1", nm, readies); end
        n_cmp++; if (got_hit !== exp_hit) begin n_err++; $display("FAIL %s hit: got %b want %b", nm, got_hit, exp_hit); end
        n_cmp++; if (got_data !== exp_data) begin n_err++; $display("FAIL %s data: got %h want %h", nm, got_data, exp_data); end
        n_cmp++; if (lat != (exp_hit ? 1 : 6)) begin n_err++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_hit ? 1 : 6); end
        n_cmp++; if (forcs != (exp_hit ? 0 : 1)) begin n_err++; $display("FAIL %s forc_pulses: got %0d want %0d", nm, forcs, exp_hit ? 0 : 1); end
        n_cmp++; if (starts != (exp_hit ? 0 : 2)) begin n_err++; $display("FAIL %s start_cycles: got %0d want %0d", nm, starts, exp_hit ? 0 : 2); end
        n_cmp++; if (both || bad_order || bad_adr) begin n_err++; $display("FAIL %s mem_protocol: overlap=%b forc_after_start=%b bad_adr=%b want 0 0 0", nm, both, bad_order, bad_adr); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (cpu_ready !== 1'b0 || cpu_data !== exp_data) begin n_err++; $display("FAIL %s hold: ready=%b data=%h want 0 %h", nm, cpu_ready, cpu_data, exp_data); end
        end
        mvalid[a[9:2]] = 1; mtag[a[9:2]] = a[14:10];
        if (exp_hit) exp_hits++; else exp_misses++;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1; cpu_rd = 1;
        @(negedge clk);
        n_cmp++; if ({cpu_busy, cpu_ready, cpu_hit, mem_start, mem_forc} !== 5'b0 || cpu_data !== 32'h0) begin
            n_err++; $display("FAIL reset_outputs: busy/ready/hit/start/forc=%b data=%h want 00000 0", {cpu_busy, cpu_ready, cpu_hit, mem_start, mem_forc}, cpu_data); end
`ifdef DCACHE_STATS_EN
        n_cmp++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin n_err++; $display("FAIL reset_counters: hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt); end
`endif
        rst = 0; cpu_rd = 0;
        for (int i = 0; i < 256; i++) mvalid[i] = 0;
        @(negedge clk);
        n_cmp++; if (cpu_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b want 0", cpu_busy); end
    endtask

    task automatic test_cold_miss();
        run_read(15'h0005, 0, "cold_0005");
    endtask

    task automatic test_hit();
        run_read(15'h0007, 0, "hit_0007");
    endtask

    task automatic test_conflict();
        run_read(15'h0405, 0, "evict_0405");
        run_read(15'h0005, 0, "reread_0005");
    endtask

    task automatic test_reset_wait();
        bit seen, rdy;
        seen = 0; rdy = 0;
        do_reset();
        @(negedge clk); cpu_rd = 1; cpu_adr = 15'h0005;
        @(negedge clk); cpu_rd = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (cpu_ready) rdy = 1;
            if (mem_start) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rst_wait_start: mem_start never seen, want 1"); end
        @(negedge clk);
        if (cpu_ready) rdy = 1;
        rst = 1;
        @(negedge clk);
        if (cpu_ready) rdy = 1;
        n_cmp++; if (mem_start !== 1'b0 || cpu_busy !== 1'b0) begin n_err++; $display("FAIL rst_wait_abandon: start=%b busy=%b want 0 0", mem_start, cpu_busy); end
        rst = 0;
        for (int i = 0; i < 256; i++) mvalid[i] = 0;
        for (int c = 0; c < 3; c++) begin @(negedge clk); if (cpu_ready) rdy = 1; end
        n_cmp++; if (rdy) begin n_err++; $display("FAIL rst_wait_ready: cpu_ready seen=1 want 0"); end
        run_read(15'h0005, 0, "rst_wait_reread");
    endtask

    task automatic test_reset_fill();
        bit started, fill, rdy;
        started = 0; fill = 0; rdy = 0;
        @(negedge clk); cpu_rd = 1; cpu_adr = 15'h0C09;
        @(negedge clk); cpu_rd = 0;
        for (int c = 0; c < 10 && !fill; c++) begin
            @(negedge clk);
            if (cpu_ready) rdy = 1;
            if (mem_start) started = 1;
            else if (started) fill = 1;
        end
        n_cmp++; if (!fill) begin n_err++; $display("FAIL rst_fill_reach: fill phase seen=0 want 1"); end
        rst = 1;
        @(negedge clk);
        if (cpu_ready) rdy = 1;
        rst = 0;
        for (int i = 0; i < 256; i++) mvalid[i] = 0;
        for (int c = 0; c < 3; c++) begin @(negedge clk); if (cpu_ready) rdy = 1; end
        n_cmp++; if (rdy || cpu_busy) begin n_err++; $display("FAIL rst_fill_ready: ready_seen=%b busy=%b want 0 0", rdy, cpu_busy); end
        run_read(15'h0C09, 0, "rst_fill_reread");
    endtask

    task automatic test_rd_held();
        run_read(15'h1234, 1, "held_miss");
        run_read(15'h1235, 1, "held_hit");
    endtask

    task automatic test_random();
        logic [14:0] a;
        for (int n = 0; n < 40; n++) begin
            a = {5'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom)};
            run_read(a, 1'($urandom), "random");
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        do_reset();
        run_read(15'h0005, 0, "stats_cold");
        run_read(15'h0007, 0, "stats_hit");
        run_read(15'h0405, 0, "stats_evict");
        run_read(15'h0005, 1, "stats_reread");
        n_cmp++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd3) begin n_err++; $display("FAIL stats_counts: hit=%0d miss=%0d want 1 3", hit_cnt, miss_cnt); end
        test_random();
        n_cmp++; if (hit_cnt !== 16'(exp_hits) || miss_cnt !== 16'(exp_misses)) begin n_err++; $display("FAIL stats_random: hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_misses); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_reset_wait();
        test_reset_fill();
        test_rd_held();
        test_random();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
